// File: rtl/draw_character.sv
// Sprite blitter: reads an SPR_W x SPR_H sprite from a sync ROM and plots it at (char_x, char_y).
// Define SPRITE_MIRROR_EN to honour facing_left as a horizontal mirror.
module draw_character #(
    parameter int         SPR_W       = 8,
    parameter int         SPR_H       = 8,
    parameter int         ADDR_WIDTH  = 6,
    parameter logic [8:0] TRANSPARENT = 9'h1FF
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [7:0]            char_x,
    input  logic [6:0]            char_y,
    input  logic                  facing_left,
    output logic [ADDR_WIDTH-1:0] rom_address,
    input  logic [8:0]            rom_data,
    output logic [7:0]            x,
    output logic [6:0]            y,
    output logic [8:0]            color,
    output logic                  plot,
    output logic                  done
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_cx;
    logic [6:0]    r_cy;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_pcol;
    logic [CW-1:0] w_rcol;
    logic [RW-1:0] r_row;
    logic [RW-1:0] r_prow;
    logic          r_pv;
    logic          w_last;
    logic          w_vis;
    logic [8:0]    w_sx;
    logic [7:0]    w_sy;
    logic [7:0]    r_x;
    logic [6:0]    r_y;
    logic [8:0]    r_color;
    logic          r_plot;
    logic          r_done;

`ifdef SPRITE_MIRROR_EN
    logic r_face;
    assign w_rcol = r_face ? (CW'(SPR_W - 1) - r_col) : r_col;
`else
    logic w_unused;
    assign w_unused = facing_left;
    assign w_rcol   = r_col;
`endif

    assign w_last = (r_col == CW'(SPR_W - 1)) && (r_row == RW'(SPR_H - 1));
    assign rom_address = (r_state == S_DRAW)
        ? ADDR_WIDTH'(32'(r_row) * SPR_W + 32'(w_rcol)) : '0;

    // Screen coordinates use the unmirrored column; clip, never wrap.
    assign w_sx  = {1'b0, r_cx} + 9'(r_pcol);
    assign w_sy  = {1'b0, r_cy} + 8'(r_prow);
    assign w_vis = r_pv && enable && (rom_data != TRANSPARENT)
                && (w_sx <= 9'd159) && (w_sy <= 8'd119);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (enable) w_next = S_DRAW;
            S_DRAW:  if (!enable) w_next = S_IDLE;
                     else if (w_last) w_next = S_FLUSH;
            S_FLUSH: w_next = enable ? S_DONE : S_IDLE;
            S_DONE:  if (!enable) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_pcol  <= '0;
            r_prow  <= '0;
            r_pv    <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            r_plot  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            r_face  <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && enable) begin
                r_cx  <= char_x;
                r_cy  <= char_y;
                r_col <= '0;
                r_row <= '0;
`ifdef SPRITE_MIRROR_EN
                r_face <= facing_left;
`endif
            end else if (r_state == S_DRAW && enable) begin
                if (r_col == CW'(SPR_W - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
            // Pipeline tag lines up with rom_data one cycle later.
            r_pv   <= (r_state == S_DRAW) && enable;
            r_pcol <= r_col;
            r_prow <= r_row;
            r_plot <= w_vis;
            if (w_vis) begin
                r_x     <= w_sx[7:0];
                r_y     <= w_sy[6:0];
                r_color <= rom_data;
            end
            r_done <= (w_next == S_DONE);
        end
    end

    assign x     = r_x;
    assign y     = r_y;
    assign color = r_color;
    assign plot  = r_plot;
    assign done  = r_done;
endmodule

// File: tb/tb_draw_character.sv
// Directed bench for draw_character: draw, transparency, clipping, abort,
// reset mid-draw and (with SPRITE_MIRROR_EN) mirroring.
module tb_draw_character;
    logic       clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic [7:0] char_x;
    logic [6:0] char_y;
    logic       facing_left;
    logic [5:0] rom_address;
    logic [8:0] rom_data;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] color;
    logic       plot;
    logic       done;

    logic [8:0] mem [64];
    int n_cmp = 0;
    int n_err = 0;
    int maxx;
    int maxy;

`ifdef SPRITE_MIRROR_EN
    localparam bit MIR = 1'b1;
`else
    localparam bit MIR = 1'b0;
`endif

    always #5 clk = ~clk;

    always_ff @(posedge clk) rom_data <= mem[rom_address];

    draw_character dut (
        .clock       (clk),
        .resetn      (resetn),
        .enable      (enable),
        .char_x      (char_x),
        .char_y      (char_y),
        .facing_left (facing_left),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .x           (x),
        .y           (y),
        .color       (color),
        .plot        (plot),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int kind);
        for (int k = 0; k < 64; k++) begin
            case (kind)
                0: mem[k] = 9'h038;
                1: mem[k] = (((k / 8) + (k % 8)) % 2 == 0) ? 9'h1C0 : 9'h1FF;
                default: mem[k] = (k % 8 == 0) ? 9'h1C0 : 9'h1FF;
            endcase
        end
    endtask

    task automatic run_draw(input logic [7:0] cx, input logic [6:0] cy,
                            input logic face, input string tag);
        logic [7:0] ex_x [64];
        logic [6:0] ex_y [64];
        logic [8:0] ex_c [64];
        int n_exp, got, bad, first, sx, sy, a, r, c;
        logic [8:0] pc;
        n_exp = 0;
        for (int k = 0; k < 64; k++) begin
            r  = k / 8;
            c  = k % 8;
            a  = r * 8 + ((MIR && face) ? 7 - c : c);
            pc = mem[a];
            sx = int'(cx) + c;
            sy = int'(cy) + r;
            if (pc != 9'h1FF && sx <= 159 && sy <= 119) begin
                ex_x[n_exp] = sx[7:0];
                ex_y[n_exp] = sy[6:0];
                ex_c[n_exp] = pc;
                n_exp++;
            end
        end
        got = 0; bad = 0; first = -1; maxx = 0; maxy = 0;
        @(negedge clk);
        char_x = cx; char_y = cy; facing_left = face; enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) chk({tag, "_addr0"}, 32'(rom_address), 0);
            if (i == 10) begin
                char_x = ~cx; char_y = ~cy; facing_left = ~face;
            end
            if (plot) begin
                if (got >= n_exp || x != ex_x[got] || y != ex_y[got]
                    || color != ex_c[got]) bad++;
                if (int'(x) > maxx) maxx = int'(x);
                if (int'(y) > maxy) maxy = int'(y);
                got++;
            end
            if (done) begin
                first = i;
                break;
            end
        end
        chk({tag, "_count"}, 32'(got), 32'(n_exp));
        chk({tag, "_order"}, 32'(bad), 0);
        chk({tag, "_done_t"}, 32'(first), 65);
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_drop"}, 32'(done), 0);
        chk({tag, "_plot_idle"}, 32'(plot), 0);
    endtask

    initial begin
        int n;
        resetn = 1'b0; enable = 1'b0; char_x = '0; char_y = '0;
        facing_left = 1'b0;
        fill(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_plot", 32'(plot), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_color", 32'(color), 0);
        chk("rst_addr", 32'(rom_address), 0);
        resetn = 1'b1;

        fill(0);
        run_draw(8'd10, 7'd20, 1'b0, "basic");
        chk("basic_n", 32'(n_cmp > 0), 1);

        fill(1);
        run_draw(8'd50, 7'd60, 1'b0, "checker");

        fill(0);
        run_draw(8'd156, 7'd116, 1'b0, "clip");
        chk("clip_maxx", 32'(maxx), 159);
        chk("clip_maxy", 32'(maxy), 119);

        // Abort at pixel 20, then restart.
        fill(0);
        @(negedge clk);
        char_x = 8'd30; char_y = 7'd40; enable = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_addr", 32'(rom_address), 20);
        enable = 1'b0;
        n = 0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (plot) n++;
            if (j == 0) chk("abort_done", 32'(done), 0);
        end
        chk("abort_plots", 32'(n), 0);
        chk("abort_addr_idle", 32'(rom_address), 0);
        run_draw(8'd30, 7'd40, 1'b0, "restart");

        // Reset at pixel 30.
        @(negedge clk);
        char_x = 8'd70; char_y = 7'd80; enable = 1'b1;
        for (int i = 0; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_x_nz", 32'(x != 8'd0), 1);
        resetn = 1'b0; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_plot", 32'(plot), 0);
        chk("mrst_x", 32'(x), 0);
        chk("mrst_y", 32'(y), 0);
        chk("mrst_color", 32'(color), 0);
        chk("mrst_addr", 32'(rom_address), 0);
        resetn = 1'b1;
        n = 0;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (plot || done) n++;
        end
        chk("mrst_quiet", 32'(n), 0);
        run_draw(8'd70, 7'd80, 1'b0, "postrst");

        // Column 0 only; mirrored builds plot it at char_x+7.
        fill(2);
        run_draw(8'd100, 7'd10, 1'b1, "mirror");
        chk("mirror_col", 32'(maxx), MIR ? 107 : 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
